serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 28 ++
 rtl/serial_subtractor_full_subtractor.sv | 33 +++
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   - state_t    : two-state FSM encoding (S_IDLE, S_SHIFT)
//   - cnt_width(): bit counter width able to hold WIDTH-1 for WIDTH in 1..32
package serial_subtractor_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;

   // CNT_W = $clog2(WIDTH)+1; the extra bit keeps WIDTH=1 at a legal 1-bit width.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Request/result bundle for serial_subtractor.
//   master : drives start, a, b, bin; observes busy, done, diff, bout
//   slave  : the subtractor side of the same signals
interface serial_subtractor_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
//   One-bit full subtractor built only from 2-input NAND primitives, matching
//   the structure of the gate-level full-adder cells.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d         : a ^ b ^ bin
//   bout      : (~a & b) | (~(a ^ b) & bin)
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic n1, n2, n3, x1;
   logic m1, m2, m3;

   // x1 = a ^ b; n3 doubles as ~(~a & b)
   nand g1 (n1, a, b);
   nand g2 (n2, a, n1);
   nand g3 (n3, b, n1);
   nand g4 (x1, n2, n3);

   // d = x1 ^ bin; m3 doubles as ~(~x1 & bin)
   nand g5 (m1, x1, bin);
   nand g6 (m2, x1, m1);
   nand g7 (m3, bin, m1);
   nand g8 (d, m2, m3);

   // bout = ~(n3 & m3) = (~a & b) | (~x1 & bin)
   nand g9 (bout, n3, m3);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH,
//   bout = 1 iff a < b + bin. Operands are captured on an accepted start and
//   processed LSB-first through one full_subtractor over WIDTH cycles.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of serial_subtractor_if (start/a/b/bin in,
//                busy/done/diff/bout out)
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_subtractor_if.slave   bus
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t             state, state_next;
   logic [WIDTH-1:0]   a_sr, b_sr, res_sr, res_next, diff_q;
   logic               br, bout_q, done_q;
   logic [CNT_W-1:0]   cnt;
   logic               d, bn;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (d),
      .bout (bn)
   );

   // Result register shifts right with the new bit entering at the MSB, so
   // after WIDTH shifts bit 0 of the operands sits at bit 0 of the result.
   always_comb begin
      res_next            = res_sr >> 1;
      res_next[WIDTH-1]   = d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_next; no latch is inferred.
      state_next = state;
      unique case (state)
         S_IDLE:  if (bus.start)   state_next = S_SHIFT;
         S_SHIFT: if (cnt == '0)   state_next = S_IDLE;
         default:                  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // NOTE: every register here is reset, including the datapath, because an
   // aborted operation must leave diff/bout at 0 and no stale operands behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so all registers update from pre-edge values.
         done_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  br     <= bus.bin;
                  cnt    <= CNT_W'(WIDTH - 1);
                  res_sr <= '0;
               end
            end
            S_SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               br     <= bn;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  diff_q <= res_next;
                  bout_q <= bn;
                  done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state == S_SHIFT);
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=1,
//   plus an exhaustive check of the full_subtractor cell.
module tb_serial_subtractor;

   logic clk;
   logic rst_n;

   int checks;
   int errors;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

   full_subtractor u_fs (
      .a    (fs_a),
      .b    (fs_b),
      .bin  (fs_bin),
      .d    (fs_d),
      .bout (fs_bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge (sampling/driving point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation on the selected DUT (w1=1 selects WIDTH=1) and wait
   // for done. Returns the observed result, edges from accept to done, whether
   // busy stayed high until done and dropped with it, and a timeout flag.
   task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, output logic [7:0] diff,
                         output logic bout, output int lat, output bit busy_ok,
                         output bit timed_out);
      busy_ok   = 1'b1;
      timed_out = 1'b1;
      lat       = 0;
      if (w1) begin
         bus1.a = a[0]; bus1.b = b[0]; bus1.bin = bin; bus1.start = 1'b1;
      end else begin
         bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
      end
      step();
      if (w1) begin
         bus1.start = 1'b0;
         if (bus1.busy !== 1'b1) busy_ok = 1'b0;
      end else begin
         bus8.start = 1'b0;
         if (bus8.busy !== 1'b1) busy_ok = 1'b0;
      end
      for (int i = 1; i <= 40; i++) begin
         step();
         if ((w1 ? bus1.done : bus8.done) === 1'b1) begin
            lat       = i;
            timed_out = 1'b0;
            if ((w1 ? bus1.busy : bus8.busy) !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if ((w1 ? bus1.busy : bus8.busy) !== 1'b1) busy_ok = 1'b0;
      end
      diff = w1 ? {7'b0, bus1.diff} : bus8.diff;
      bout = w1 ? bus1.bout : bus8.bout;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'b0) begin
         errors++;
         $display("FAIL reset_w8 got busy=%b done=%b diff=%h bout=%b expected all 0",
                  bus8.busy, bus8.done, bus8.diff, bus8.bout);
      end
      checks++;
      if ({bus1.busy, bus1.done, bus1.diff, bus1.bout} !== 4'b0) begin
         errors++;
         $display("FAIL reset_w1 got busy=%b done=%b diff=%b bout=%b expected all 0",
                  bus1.busy, bus1.done, bus1.diff, bus1.bout);
      end
      repeat (2) step();
      rst_n = 1'b1;
      step();
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b done=%b expected 0 0",
                  bus8.busy, bus8.done);
      end
   endtask

   task automatic test_basic();
      logic [7:0] diff; logic bout; int lat; bit busy_ok, to;
      run_op(1'b0, 8'h5A, 8'h3C, 1'b0, diff, bout, lat, busy_ok, to);
      checks++;
      if (to || lat != 8) begin
         errors++;
         $display("FAIL basic_latency got %0d (timeout=%0b) expected 8", lat, to);
      end
      checks++;
      if (!busy_ok) begin
         errors++;
         $display("FAIL basic_busy got busy profile wrong expected high k..k+8");
      end
      checks++;
      if ({bout, diff} !== {1'b0, 8'h1E}) begin
         errors++;
         $display("FAIL basic_result got diff=%h bout=%b expected diff=1e bout=0",
                  diff, bout);
      end
      step();
      checks++;
      if (bus8.done !== 1'b0 || bus8.diff !== 8'h1E || bus8.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_hold got done=%b diff=%h busy=%b expected 0 1e 0",
                  bus8.done, bus8.diff, bus8.busy);
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] diff; logic bout; int lat; bit busy_ok, to;
      run_op(1'b0, 8'h00, 8'h01, 1'b0, diff, bout, lat, busy_ok, to);
      checks++;
      if (to || {bout, diff} !== {1'b1, 8'hFF}) begin
         errors++;
         $display("FAIL underflow got diff=%h bout=%b expected ff 1", diff, bout);
      end
      run_op(1'b0, 8'h80, 8'h7F, 1'b1, diff, bout, lat, busy_ok, to);
      checks++;
      if (to || {bout, diff} !== {1'b0, 8'h00}) begin
         errors++;
         $display("FAIL borrow_in_zero got diff=%h bout=%b expected 00 0", diff, bout);
      end
      run_op(1'b0, 8'hFF, 8'hFF, 1'b1, diff, bout, lat, busy_ok, to);
      checks++;
      if (to || {bout, diff} !== {1'b1, 8'hFF}) begin
         errors++;
         $display("FAIL equal_with_bin got diff=%h bout=%b expected ff 1", diff, bout);
      end
      run_op(1'b0, 8'hFF, 8'h00, 1'b0, diff, bout, lat, busy_ok, to);
      checks++;
      if (to || {bout, diff} !== {1'b0, 8'hFF}) begin
         errors++;
         $display("FAIL max_minus_zero got diff=%h bout=%b expected ff 0", diff, bout);
      end
   endtask

   task automatic test_back_to_back();
      int dones;
      int lat2;
      dones = 0;
      bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
      step();
      // Keep start high and scramble operands while busy.
      for (int i = 1; i <= 8; i++) begin
         bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
         step();
         if (bus8.done === 1'b1) dones++;
      end
      checks++;
      if (dones != 1 || bus8.done !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start_dones got %0d done_now=%b expected 1 1",
                  dones, bus8.done);
      end
      checks++;
      if ({bus8.bout, bus8.diff} !== {1'b0, 8'h0F}) begin
         errors++;
         $display("FAIL ignore_start_result got diff=%h bout=%b expected 0f 0",
                  bus8.diff, bus8.bout);
      end
      // Operands on the done cycle are accepted at the next edge.
      bus8.a = 8'h22; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      checks++;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept got busy=%b done=%b expected 1 0",
                  bus8.busy, bus8.done);
      end
      lat2 = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus8.done === 1'b1) begin
            lat2 = i;
            break;
         end
      end
      checks++;
      if (lat2 != 8 || {bus8.bout, bus8.diff} !== {1'b0, 8'h11}) begin
         errors++;
         $display("FAIL b2b_second got lat=%0d diff=%h bout=%b expected 8 11 0",
                  lat2, bus8.diff, bus8.bout);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] diff; logic bout; int lat; bit busy_ok, to;
      int dones;
      bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b0; bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'b0) begin
         errors++;
         $display("FAIL reset_mid got busy=%b done=%b diff=%h bout=%b expected all 0",
                  bus8.busy, bus8.done, bus8.diff, bus8.bout);
      end
      #3;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL reset_mid_abort got %0d active cycles expected 0", dones);
      end
      run_op(1'b0, 8'h03, 8'h05, 1'b0, diff, bout, lat, busy_ok, to);
      checks++;
      if (to || {bout, diff} !== {1'b1, 8'hFE}) begin
         errors++;
         $display("FAIL after_reset_op got diff=%h bout=%b expected fe 1", diff, bout);
      end
   endtask

   task automatic test_full_subtractor();
      // Truth tables indexed by {a,b,bin}.
      logic [7:0] d_tab;
      logic [7:0] b_tab;
      logic [2:0] idx;
      d_tab = 8'b1001_0110;
      b_tab = 8'b1000_1110;
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         {fs_a, fs_b, fs_bin} = idx;
         #1;
         checks++;
         if ({fs_d, fs_bout} !== {d_tab[idx], b_tab[idx]}) begin
            errors++;
            $display("FAIL fs_%0d got d=%b bout=%b expected d=%b bout=%b",
                     i, fs_d, fs_bout, d_tab[idx], b_tab[idx]);
         end
      end
   endtask

   task automatic test_random(input bit w1);
      logic [7:0] a, b, diff; logic bin, bout; int lat; bit busy_ok, to;
      logic [8:0] m8;
      logic [1:0] m1;
      logic [8:0] exp_res;
      int exp_lat;
      exp_lat = w1 ? 1 : 8;
      for (int n = 0; n < 1000; n++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         bin = 1'($urandom);
         run_op(w1, a, b, bin, diff, bout, lat, busy_ok, to);
         if (w1) begin
            m1      = {1'b0, a[0]} - {1'b0, b[0]} - {1'b0, bin};
            exp_res = {m1[1], 7'b0, m1[0]};
         end else begin
            m8      = {1'b0, a} - {1'b0, b} - {8'b0, bin};
            exp_res = m8;
         end
         checks++;
         if (to || lat != exp_lat || !busy_ok || {bout, diff} !== exp_res) begin
            errors++;
            $display("FAIL random_w%0d a=%h b=%h bin=%b got diff=%h bout=%b lat=%0d expected diff=%h bout=%b lat=%0d",
                     w1 ? 1 : 8, a, b, bin, diff, bout, lat, exp_res[7:0],
                     exp_res[8], exp_lat);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
      fs_a = 1'b0; fs_b = 1'b0; fs_bin = 1'b0;

      test_reset();
      test_basic();
      test_boundaries();
      test_back_to_back();
      test_reset_mid();
      test_full_subtractor();
      test_random(1'b0);
      test_random(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
